// File: rtl/difftest_commit_fifo.sv
// Difftest commit-trace FIFO: packs fired CMT lanes, tags them with sequence numbers, drains one per cycle.
// tr_* is registered (push in N, visible in N+1); NCPU_DIFFTEST_STALL_EN turns on cmt_stall, otherwise overflowing groups are dropped.
module difftest_commit_fifo #(
   parameter int CONFIG_DW             = 64,
   parameter int CONFIG_P_COMMIT_WIDTH = 1,
   parameter int CONFIG_NUM_IRQ        = 32,
   parameter int CONFIG_P_FIFO_DEPTH   = 4,
   parameter int PC_W                  = 30,
   localparam int CW                   = 1 << CONFIG_P_COMMIT_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [CW-1:0]                  cmt_fire,
   input  logic [PC_W*CW-1:0]             cmt_pc,
   input  logic [32*CW-1:0]               cmt_ins,
   input  logic [CW-1:0]                  cmt_lrd_we,
   input  logic [5*CW-1:0]                cmt_lrd,
   input  logic [CONFIG_DW*CW-1:0]        cmt_lrd_dat,
   input  logic                           cmt_exc,
   input  logic [31:0]                    cmt_exc_vect,
   input  logic [CONFIG_NUM_IRQ-1:0]      msr_irqc_irr,
   output logic                           cmt_stall,
   output logic                           tr_valid,
   input  logic                           tr_ready,
   output logic [31:0]                    tr_seq,
   output logic [PC_W-1:0]                tr_pc,
   output logic [31:0]                    tr_ins,
   output logic                           tr_wen,
   output logic [4:0]                     tr_wnum,
   output logic [CONFIG_DW-1:0]           tr_wdat,
   output logic                           tr_excp,
   output logic [31:0]                    tr_excp_vect,
   output logic [CONFIG_NUM_IRQ-1:0]      tr_irr,
   output logic [CONFIG_P_FIFO_DEPTH:0]   fifo_cnt,
   output logic [15:0]                    ovf_cnt
);

   localparam int D     = 1 << CONFIG_P_FIFO_DEPTH;
   localparam int P     = CONFIG_P_FIFO_DEPTH;
   localparam int CNT_W = P + 1;

   typedef struct packed {
      logic [31:0]               seq;
      logic [PC_W-1:0]           pc;
      logic [31:0]               ins;
      logic                      wen;
      logic [4:0]                wnum;
      logic [CONFIG_DW-1:0]      wdat;
      logic                      excp;
      logic [31:0]               vect;
      logic [CONFIG_NUM_IRQ-1:0] irr;
   } rec_t;

   rec_t             r_mem [D];
   logic [P-1:0]     r_wptr;
   logic [P-1:0]     r_rptr;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_seq;
   logic [15:0]      r_ovf;

   logic [CNT_W-1:0] w_npush;
   logic [P-1:0]     w_off [CW];
   logic [P-1:0]     w_waddr [CW];
   logic [CW-1:0]    w_exc_mask;
   logic             w_exc_only;
   rec_t             w_rec [CW];
   logic [CNT_W:0]   w_free;
   logic             w_pop;
   logic             w_fits;
   logic             w_admit;
   logic             w_drop;

   // Slot offset of each lane is the number of fired lanes below it; the exception
   // mask ends up one-hot on the highest fired lane.
   always_comb begin
      w_npush    = '0;
      w_exc_mask = '0;
      for (int l = 0; l < CW; l++) begin
         w_off[l] = w_npush[P-1:0];
         if (cmt_fire[l]) begin
            w_npush       = w_npush + CNT_W'(1);
            w_exc_mask    = '0;
            w_exc_mask[l] = 1'b1;
         end
      end
      w_exc_only = cmt_exc && (cmt_fire == '0);
      if (w_exc_only) begin
         w_npush = CNT_W'(1);
      end
   end

   always_comb begin
      for (int l = 0; l < CW; l++) begin
         w_rec[l].seq = r_seq + 32'(w_off[l]);
         w_rec[l].pc  = cmt_pc[l*PC_W +: PC_W];
         w_rec[l].ins = cmt_ins[l*32 +: 32];
         if (w_exc_only) begin
            w_rec[l].wen  = 1'b0;
            w_rec[l].wnum = '0;
            w_rec[l].wdat = '0;
            w_rec[l].excp = 1'b1;
         end else begin
            w_rec[l].wen  = cmt_lrd_we[l];
            w_rec[l].wnum = cmt_lrd[l*5 +: 5];
            w_rec[l].wdat = cmt_lrd_dat[l*CONFIG_DW +: CONFIG_DW];
            w_rec[l].excp = cmt_exc & w_exc_mask[l];
         end
         w_rec[l].vect = w_rec[l].excp ? cmt_exc_vect : '0;
         w_rec[l].irr  = w_rec[l].excp ? msr_irqc_irr : '0;
         w_waddr[l]    = r_wptr + w_off[l];
      end
   end

   assign w_pop   = (r_cnt != '0) && tr_ready;
   // A pop in the same cycle frees its slot for this cycle's group.
   assign w_free  = (CNT_W+1)'(D) - {1'b0, r_cnt} + (CNT_W+1)'(w_pop);
   assign w_fits  = {1'b0, w_npush} <= w_free;
   assign w_admit = (w_npush != '0) && w_fits;
   assign w_drop  = (w_npush != '0) && !w_fits;

   always_ff @(posedge clk) begin
      if (w_admit) begin
         for (int l = 0; l < CW; l++) begin
            if (cmt_fire[l] || (w_exc_only && l == 0)) begin
               r_mem[w_waddr[l]] <= w_rec[l];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
         r_seq  <= '0;
         r_ovf  <= '0;
      end else begin
         if (w_admit) begin
            r_wptr <= r_wptr + w_npush[P-1:0];
            r_seq  <= r_seq + 32'(w_npush);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + P'(1);
         end
         r_cnt <= r_cnt + (w_admit ? w_npush : '0) - CNT_W'(w_pop);
         if (w_drop && r_ovf != 16'hFFFF) begin
            r_ovf <= r_ovf + 16'd1;
         end
      end
   end

`ifdef NCPU_DIFFTEST_STALL_EN
   assign cmt_stall = ((CNT_W+1)'(D) - {1'b0, r_cnt}) < (CNT_W+1)'(CW);
`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n && w_drop) begin
         $fatal(1, "difftest_commit_fifo: CMT fired past cmt_stall, group dropped");
      end
   end
`endif
`else
   assign cmt_stall = 1'b0;
`endif

   assign tr_valid     = (r_cnt != '0);
   assign tr_seq       = r_mem[r_rptr].seq;
   assign tr_pc        = r_mem[r_rptr].pc;
   assign tr_ins       = r_mem[r_rptr].ins;
   assign tr_wen       = r_mem[r_rptr].wen;
   assign tr_wnum      = r_mem[r_rptr].wnum;
   assign tr_wdat      = r_mem[r_rptr].wdat;
   assign tr_excp      = r_mem[r_rptr].excp;
   assign tr_excp_vect = r_mem[r_rptr].vect;
   assign tr_irr       = r_mem[r_rptr].irr;
   assign fifo_cnt     = r_cnt;
   assign ovf_cnt      = r_ovf;

endmodule

// File: tb/tb_difftest_commit_fifo.sv
// Scoreboard bench for difftest_commit_fifo at CW=2, D=16.
module tb_difftest_commit_fifo;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    cmt_fire;
   logic [59:0]   cmt_pc;
   logic [63:0]   cmt_ins;
   logic [1:0]    cmt_lrd_we;
   logic [9:0]    cmt_lrd;
   logic [127:0]  cmt_lrd_dat;
   logic          cmt_exc;
   logic [31:0]   cmt_exc_vect;
   logic [31:0]   msr_irqc_irr;
   logic          cmt_stall;
   logic          tr_valid;
   logic          tr_ready;
   logic [31:0]   tr_seq;
   logic [29:0]   tr_pc;
   logic [31:0]   tr_ins;
   logic          tr_wen;
   logic [4:0]    tr_wnum;
   logic [63:0]   tr_wdat;
   logic          tr_excp;
   logic [31:0]   tr_excp_vect;
   logic [31:0]   tr_irr;
   logic [4:0]    fifo_cnt;
   logic [15:0]   ovf_cnt;

   typedef struct {
      logic [31:0] seq;
      logic [29:0] pc;
      logic [31:0] ins;
      logic        wen;
      logic [4:0]  wnum;
      logic [63:0] wdat;
      logic        excp;
      logic [31:0] vect;
      logic [31:0] irr;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned m_seq = 0;
   int          n_checks = 0;
   int          n_errs = 0;

   difftest_commit_fifo dut (
      .clk(clk), .rst_n(rst_n),
      .cmt_fire(cmt_fire), .cmt_pc(cmt_pc), .cmt_ins(cmt_ins),
      .cmt_lrd_we(cmt_lrd_we), .cmt_lrd(cmt_lrd), .cmt_lrd_dat(cmt_lrd_dat),
      .cmt_exc(cmt_exc), .cmt_exc_vect(cmt_exc_vect), .msr_irqc_irr(msr_irqc_irr),
      .cmt_stall(cmt_stall), .tr_valid(tr_valid), .tr_ready(tr_ready),
      .tr_seq(tr_seq), .tr_pc(tr_pc), .tr_ins(tr_ins), .tr_wen(tr_wen),
      .tr_wnum(tr_wnum), .tr_wdat(tr_wdat), .tr_excp(tr_excp),
      .tr_excp_vect(tr_excp_vect), .tr_irr(tr_irr),
      .fifo_cnt(fifo_cnt), .ovf_cnt(ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drives one CMT cycle; when admit is set the expected records go to the scoreboard.
   task automatic drive(input logic [1:0] fire, input logic [29:0] pc0, input logic [29:0] pc1,
                        input logic exc, input logic [31:0] vect, input bit admit);
      exp_t r;
      cmt_fire     = fire;
      cmt_pc       = {pc1, pc0};
      cmt_ins      = {$urandom, $urandom};
      cmt_lrd_we   = 2'($urandom);
      cmt_lrd      = 10'($urandom);
      cmt_lrd_dat  = {$urandom, $urandom, $urandom, $urandom};
      cmt_exc      = exc;
      cmt_exc_vect = vect;
      msr_irqc_irr = $urandom;
      if (admit) begin
         if (fire == 2'b00 && exc) begin
            r.seq = m_seq; r.pc = pc0; r.ins = cmt_ins[31:0];
            r.wen = 1'b0; r.wnum = '0; r.wdat = '0;
            r.excp = 1'b1; r.vect = vect; r.irr = msr_irqc_irr;
            sb_q.push_back(r);
            m_seq++;
         end else begin
            for (int l = 0; l < 2; l++) begin
               if (fire[l]) begin
                  r.seq  = m_seq;
                  r.pc   = (l == 1) ? pc1 : pc0;
                  r.ins  = cmt_ins[l*32 +: 32];
                  r.wen  = cmt_lrd_we[l];
                  r.wnum = cmt_lrd[l*5 +: 5];
                  r.wdat = cmt_lrd_dat[l*64 +: 64];
                  r.excp = exc && (l == 1 || !fire[1]);
                  r.vect = r.excp ? vect : 32'h0;
                  r.irr  = r.excp ? msr_irqc_irr : 32'h0;
                  sb_q.push_back(r);
                  m_seq++;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      cmt_fire = '0;
      cmt_exc  = 1'b0;
   endtask

   always @(negedge clk) begin
      if (tr_valid && tr_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_rec", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("seq", 64'(tr_seq), 64'(e.seq));
            chk("pc", 64'(tr_pc), 64'(e.pc));
            chk("ins", 64'(tr_ins), 64'(e.ins));
            chk("wen", 64'(tr_wen), 64'(e.wen));
            if (e.wen) begin
               chk("wnum", 64'(tr_wnum), 64'(e.wnum));
               chk("wdat", tr_wdat, e.wdat);
            end
            chk("excp", 64'(tr_excp), 64'(e.excp));
            if (e.excp) chk("vect", 64'(tr_excp_vect), 64'(e.vect));
            chk("irr", 64'(tr_irr), 64'(e.irr));
         end
      end
   end

   initial begin
      rst_n = 1'b0; tr_ready = 1'b1;
      cmt_fire = '0; cmt_pc = '0; cmt_ins = '0; cmt_lrd_we = '0; cmt_lrd = '0;
      cmt_lrd_dat = '0; cmt_exc = 1'b0; cmt_exc_vect = '0; msr_irqc_irr = '0;
      #12;
      chk("rst_valid", 64'(tr_valid), 64'd0);
      chk("rst_cnt", 64'(fifo_cnt), 64'd0);
      chk("rst_ovf", 64'(ovf_cnt), 64'd0);
      chk("rst_stall", 64'(cmt_stall), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Two-lane group drains in lane order, then the FIFO goes empty.
      drive(2'b11, 30'h100, 30'h101, 1'b0, 32'h0, 1'b1);
      chk("g1_valid", 64'(tr_valid), 64'd1);
      chk("g1_cnt", 64'(fifo_cnt), 64'd2);
      repeat (3) @(posedge clk);
      #1;
      chk("g1_drained", 64'(tr_valid), 64'd0);

      // Lane-1 only.
      chk("g2_cnt0", 64'(fifo_cnt), 64'd0);
      drive(2'b10, 30'h200, 30'h201, 1'b0, 32'h0, 1'b1);
      chk("g2_cnt1", 64'(fifo_cnt), 64'd1);
      @(posedge clk); #1;
      chk("g2_cnt2", 64'(fifo_cnt), 64'd0);

      // Exception on both lanes, then exception with no fire.
      drive(2'b11, 30'h300, 30'h301, 1'b1, 32'h80, 1'b1);
      drive(2'b00, 30'h400, 30'h401, 1'b1, 32'h44, 1'b1);
      drive(2'b01, 30'h500, 30'h501, 1'b1, 32'h90, 1'b1);
      repeat (6) @(posedge clk);
      #1;
      chk("pre_fill_cnt", 64'(fifo_cnt), 64'd0);

      // Fill to capacity with the checker stalled.
      tr_ready = 1'b0;
      for (int g = 0; g < 8; g++) begin
         drive(2'b11, 30'(32'h600 + 2*g), 30'(32'h601 + 2*g), 1'b0, 32'h0, 1'b1);
      end
      chk("full_cnt", 64'(fifo_cnt), 64'd16);
`ifdef NCPU_DIFFTEST_STALL_EN
      chk("full_stall", 64'(cmt_stall), 64'd1);
`else
      chk("full_stall", 64'(cmt_stall), 64'd0);
      drive(2'b11, 30'h700, 30'h701, 1'b0, 32'h0, 1'b0);
      chk("ovf_cnt", 64'(ovf_cnt), 64'd1);
      chk("ovf_fifo_cnt", 64'(fifo_cnt), 64'd16);
`endif

      // Push and pop together while full.
      tr_ready = 1'b1;
      drive(2'b01, 30'h800, 30'h801, 1'b0, 32'h0, 1'b1);
      chk("full_pushpop_cnt", 64'(fifo_cnt), 64'd16);
      @(posedge clk); #1;
      chk("drain_cnt", 64'(fifo_cnt), 64'd15);

      // Asynchronous reset mid-drain discards everything.
      #2;
      rst_n = 1'b0;
      sb_q.delete();
      m_seq = 0;
      #1;
      chk("arst_valid", 64'(tr_valid), 64'd0);
      chk("arst_cnt", 64'(fifo_cnt), 64'd0);
      chk("arst_ovf", 64'(ovf_cnt), 64'd0);
      #10;
      rst_n = 1'b1;
      @(posedge clk); #1;
      drive(2'b01, 30'h900, 30'h901, 1'b0, 32'h0, 1'b1);
      chk("post_rst_cnt", 64'(fifo_cnt), 64'd1);

      repeat (20) @(posedge clk);
      #1;
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      chk("end_cnt", 64'(fifo_cnt), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/difftest_commit_fifo.md
# difftest_commit_fifo

Parametrised difftest commit-trace buffer for the ncpu64k core.
- Captures up to 2^CONFIG_P_COMMIT_WIDTH retired instructions per cycle from the CMT stage.
- Packs the valid lanes in lane order, tags each record with a running sequence number, and buffers the records in a FIFO.
- Drains one record per cycle to the difftest/DPI checker over a valid/ready handshake.
- Sits between CMT and the difftest harness, and replaces direct per-lane DPI calls so the checker can apply backpressure.

## Interface
Parameters:
- CONFIG_DW, 64, register data width.
- CONFIG_P_COMMIT_WIDTH, 1, log2 of commit lanes CW.
- CONFIG_NUM_IRQ, 32, IRQ request vector width.
- CONFIG_P_FIFO_DEPTH, 4, log2 of FIFO entries D. D >= 2*CW is required.
- PC_W, 30, word-address PC width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmt_fire  in  CW  per-lane retire strobe.
- cmt_pc  in  PC_W*CW  per-lane PC.
- cmt_ins  in  32*CW  per-lane instruction word.
- cmt_lrd_we  in  CW  per-lane register write enable.
- cmt_lrd  in  5*CW  per-lane destination register.
- cmt_lrd_dat  in  CONFIG_DW*CW  per-lane write data.
- cmt_exc  in  1  exception taken this cycle.
- cmt_exc_vect  in  32  exception vector.
- msr_irqc_irr  in  CONFIG_NUM_IRQ  IRQ pending snapshot.
- cmt_stall  out  1  backpressure to CMT. Driven only with NCPU_DIFFTEST_STALL_EN; otherwise tied 0.
- tr_valid  out  1  head record valid.
- tr_ready  in  1  checker accepts head.
- tr_seq  out  32  record sequence number.
- tr_pc, tr_ins, tr_wen, tr_wnum, tr_wdat, tr_excp, tr_excp_vect, tr_irr  out  (field widths)  head record fields.
- fifo_cnt  out  CONFIG_P_FIFO_DEPTH+1  occupancy.
- ovf_cnt  out  16  dropped-group counter. Saturates at 0xFFFF.

## Operation
Record count per cycle:
- npush = popcount(cmt_fire), plus 1 if cmt_exc and cmt_fire==0.

Packing:
- Fired lanes are written to wptr, wptr+1, ... in ascending lane order. Gaps in cmt_fire are allowed.
- The exception attaches to the highest-numbered fired lane: excp=1, excp_vect, irr = msr_irqc_irr. Every other record in the group carries excp=0 and irr=0.
- cmt_exc with no fire pushes a single record with pc/ins from lane 0, wen=0 and excp=1.

Sequence numbers:
- A 32-bit seq counter is assigned per pushed record in push order.
- It advances by npush and wraps modulo 2^32. Reset value is 0.

Handshake and pointers:
- pop = tr_valid & tr_ready.
- tr_* fields are read from the entry at rptr.
- rptr and wptr wrap modulo D.
- count_next = count + npush - pop. Simultaneous push and pop is legal at any occupancy, including full with pop.

Admission is all-or-nothing per cycle. A group is admitted iff npush <= D - count + pop; otherwise the handling is as defined under ## Configuration.

Reset:
- Clears rptr, wptr, count, seq and ovf_cnt.
- tr_valid=0, cmt_stall=0, fifo_cnt=0, ovf_cnt=0.
- Array contents are not reset.
- Reset asserted mid-drain discards all buffered records immediately (asynchronous).

## Timing
- A group pushed in cycle N presents its first record as tr_valid=1 in cycle N+1. There is no combinational path from cmt_* inputs to tr_*.
- Throughput is 1 record per cycle at the output. Pop in cycle N exposes the next entry in N+1.
- tr_valid = (count != 0). Fields are held stable while tr_valid=1 and tr_ready=0.
- cmt_stall is a function of the count register only:
  - asserted when D - count < CW;
  - it has no path from tr_ready or cmt_fire.
- fifo_cnt is the registered count.

## Configuration
Macro: NCPU_DIFFTEST_STALL_EN.

Defined:
- cmt_stall is driven as specified in ## Timing.
- CMT must not fire while cmt_stall=1.
- A group arriving while it exceeds free space is a protocol error: the group is dropped, ovf_cnt increments, and the simulation-only $fatal fires.

Undefined:
- cmt_stall=0 at all times.
- A group that does not fit is dropped entirely: no partial write, seq does not advance, ovf_cnt increments and saturates.
- Subsequent groups are admitted normally once space exists.

## Test plan
- Reset, CW=2, D=16, tr_ready=1; fire=2'b11 with pc 0x100/0x101 -> next cycle tr_valid=1, seq 0 (pc 0x100), then seq 1 (pc 0x101), then tr_valid=0.
- fire=2'b10 only -> single record with lane-1 pc and seq continuing from the prior value; fifo_cnt goes 0 -> 1 -> 0.
- fire=2'b11 plus cmt_exc, vect 0x80 -> lane-1 record has excp=1, vect 0x80, irr = snapshot; lane-0 record has excp=0.
- cmt_exc with fire=0 -> one record with wen=0, excp=1, seq incremented by 1.
- tr_ready=0; push 8 groups of 2 -> fifo_cnt=16.
  - Without the macro, a 9th group gives ovf_cnt=1 and fifo_cnt stays 16.
  - With the macro, cmt_stall=1 from the cycle count reaches 15.
- Full FIFO, tr_ready=1, fire=2'b01 in the same cycle -> push is admitted and fifo_cnt=16 is held. Then assert rst_n=0 mid-drain -> tr_valid=0 and fifo_cnt=0 asynchronously.
